mac8_sequencer: RTL and testbench
=================================

# mac8_sequencer

Control sequencer for the eight-MAC 8x8 signed matrix multiplier. It accepts a `start` pulse and drives the column-word read port of RAM A, the byte read port of RAM B, the enable/clear strobes of the eight MAC lanes, and the output-RAM write port. It produces C = A x B column by column, reports `done` and a cycle count, and sits between the top-level start/done handshake and the MAC datapath.

## Interface
- `COUNT_W`, 11: width of `clock_count`.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `a_re`  out  1  RAM A read enable.
- `a_addr`  out  3  RAM A column address k; word holds A(0..7,k).
- `b_re`  out  1  RAM B read enable.
- `b_addr`  out  6  RAM B byte address, 8i+k = B(k,i).
- `mac_en`  out  1  all eight lanes accumulate the product on RAM data.
- `mac_clr`  out  1  qualifies `mac_en`; lanes load the product instead of adding.
- `out_sel`  out  3  lane j routed to the output RAM.
- `c_we`  out  1  output RAM write enable.
- `c_addr`  out  6  output RAM address, 8i+j = C(j,i).
- `busy`  out  1  high from ACC through DONE inclusive.
- `done`  out  1  one-cycle completion pulse.
- `clock_count`  out  COUNT_W  run length in cycles.

## Operation
- Storage is column-major: element (r,c) sits at 8c+r. RAM read latency is 1 cycle. Lane j accumulates C(j,i) = sum over k of A(j,k)*B(k,i).
- FSM states: IDLE, ACC, WAIT, DRAIN, DONE. Counters: column i (0..7), k (0..7), j (0..7).
- IDLE: when `start`=1, clear `clock_count`, set i=k=0, go to ACC.
- ACC: `a_re`=`b_re`=1, `a_addr`=k, `b_addr`=8i+k, then k++.
  - k=7 goes to WAIT.
- `mac_en` is the one-cycle-delayed copy of ACC. `mac_clr` is the one-cycle-delayed copy of (ACC and k==0).
- WAIT: one cycle covering the k=7 accumulate. Then go to DRAIN with j=0.
- DRAIN: `c_we`=1, `out_sel`=j, `c_addr`=8i+j, then j++.
  - j=7 with i<7: i++, k=0, go to ACC.
  - j=7 with i=7: go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `clock_count` increments on every edge while in ACC, WAIT or DRAIN. It holds its value in DONE and IDLE until the next accepted `start`. It never wraps within a run (maximum 136).
- Address outputs: 0 whenever the matching enable is low.
- Start handling:
  - `start` outside IDLE is ignored. No queuing, no restart.
  - `start` held high re-arms in IDLE, so back-to-back runs are separated by exactly one IDLE cycle after DONE.
- `reset_n` low, asynchronously and at any point: state=IDLE, all counters=0, all outputs 0. There are no further RAM writes. A partially written output RAM is left as is.

## Timing
- Cycle 0 is the edge that samples `start`.
  - Column i uses ACC in cycles 1+17i .. 8+17i, WAIT in 9+17i, and DRAIN in 10+17i .. 17+17i.
- `mac_en` is high in cycles 2+17i .. 9+17i. `mac_clr` is high in cycle 2+17i.
- The first `c_we` is in cycle 10. The last `c_we` is in cycle 136, with `c_addr`=63.
- `done` is high in cycle 137, with `clock_count`=136. `busy` falls in cycle 138.
- There are 64 `c_we` pulses per run, with `c_addr` strictly increasing 0..63.
- All outputs are registered or decoded from registered state. There are no combinational paths from `start`.

## Test plan
- Reset, then a 1-cycle `start`.
  - Expect `done` exactly 137 cycles later with `clock_count`=136.
  - Expect `busy` high for cycles 1..137.
- Address trace, column 3:
  - ACC cycles 52..59 show `a_addr` 0..7 and `b_addr` 24..31.
  - `mac_clr` is high only in cycle 53.
  - DRAIN cycles 61..68 show `c_addr` 24..31 and `out_sel` 0..7.
- Integrated with the MAC datapath, A=identity and B(r,c)=8c+r-32 (signed).
  - Output RAM equals B.
- Integrated, A=B=all -128.
  - Every C element is 131072 in 19 bits with no overflow.
- `start` pulsed at cycle 40 of a run has no effect, and completion stays at cycle 137.
- `start` held high gives a second run whose `done` is at cycle 275.
- `reset_n` low at cycle 70, asynchronously mid-cycle.
  - All outputs are 0 before the next edge and `c_we` never rises again.
  - After release, a new `start` completes normally with `clock_count`=136.

Source files
------------

// File: rtl/mac8_sequencer.sv
// mac8_sequencer
//   Control sequencer for the eight-lane 8x8 signed matrix multiplier.
//   Walks column i of B: eight RAM reads (k = 0..7) feed the MAC lanes,
//   one WAIT cycle lets the last product land, then eight output writes
//   (j = 0..7) drain lane j into C(j,i). Repeats for i = 0..7, then pulses done.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               run request, sampled only in IDLE
//   a_re, a_addr        RAM A column-word read (address k)
//   b_re, b_addr        RAM B byte read (address 8i+k)
//   mac_en, mac_clr     lane accumulate strobe / load-instead-of-add qualifier
//   out_sel             lane routed to the output RAM
//   c_we, c_addr        output RAM write (address 8i+j)
//   busy, done          run in progress / one-cycle completion pulse
//   clock_count         cycles spent in ACC, WAIT and DRAIN for the last run
module mac8_sequencer #(
    parameter int unsigned COUNT_W = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               a_re,
    output logic [2:0]         a_addr,
    output logic               b_re,
    output logic [5:0]         b_addr,
    output logic               mac_en,
    output logic               mac_clr,
    output logic [2:0]         out_sel,
    output logic               c_we,
    output logic [5:0]         c_addr,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] clock_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [2:0]           i_q, k_q, j_q;
    logic                 a_re_q, b_re_q, mac_en_q, mac_clr_q, c_we_q;
    logic                 busy_q, done_q;
    logic [2:0]           a_addr_q, out_sel_q;
    logic [5:0]           b_addr_q, c_addr_q;
    logic [COUNT_W-1:0]   count_q;

    // Outputs are registered alongside the state: each branch loads the
    // values that belong to the state being entered, so they line up with
    // state_q without any decode after the flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            k_q       <= '0;
            j_q       <= '0;
            a_re_q    <= 1'b0;
            b_re_q    <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
            out_sel_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            // Lane strobes trail the read by one cycle (RAM read latency).
            mac_en_q  <= (state_q == S_ACC);
            mac_clr_q <= (state_q == S_ACC) && (k_q == 3'd0);

            a_re_q    <= 1'b0;
            b_re_q    <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
            out_sel_q <= '0;
            done_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ACC;
                        count_q <= '0;
                        i_q     <= '0;
                        k_q     <= '0;
                        a_re_q  <= 1'b1;
                        b_re_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_ACC: begin
                    count_q <= count_q + COUNT_W'(1);
                    if (k_q == 3'd7) begin
                        state_q <= S_WAIT;
                        k_q     <= '0;
                    end else begin
                        k_q      <= k_q + 3'd1;
                        a_re_q   <= 1'b1;
                        b_re_q   <= 1'b1;
                        a_addr_q <= k_q + 3'd1;
                        b_addr_q <= {i_q, k_q + 3'd1};
                    end
                end
                S_WAIT: begin
                    count_q  <= count_q + COUNT_W'(1);
                    state_q  <= S_DRAIN;
                    j_q      <= '0;
                    c_we_q   <= 1'b1;
                    c_addr_q <= {i_q, 3'd0};
                end
                S_DRAIN: begin
                    count_q <= count_q + COUNT_W'(1);
                    if (j_q == 3'd7) begin
                        j_q <= '0;
                        if (i_q == 3'd7) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_ACC;
                            i_q      <= i_q + 3'd1;
                            k_q      <= '0;
                            a_re_q   <= 1'b1;
                            b_re_q   <= 1'b1;
                            b_addr_q <= {i_q + 3'd1, 3'd0};
                        end
                    end else begin
                        j_q       <= j_q + 3'd1;
                        c_we_q    <= 1'b1;
                        c_addr_q  <= {i_q, j_q + 3'd1};
                        out_sel_q <= j_q + 3'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_re        = a_re_q;
    assign a_addr      = a_addr_q;
    assign b_re        = b_re_q;
    assign b_addr      = b_addr_q;
    assign mac_en      = mac_en_q;
    assign mac_clr     = mac_clr_q;
    assign out_sel     = out_sel_q;
    assign c_we        = c_we_q;
    assign c_addr      = c_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign clock_count = count_q;

endmodule

// File: tb/tb_mac8_sequencer.sv
module tb_mac8_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        a_re, b_re, mac_en, mac_clr, c_we, busy, done;
    logic [2:0]  a_addr, out_sel;
    logic [5:0]  b_addr, c_addr;
    logic [10:0] clock_count;

    mac8_sequencer #(.COUNT_W(11)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .a_re(a_re), .a_addr(a_addr), .b_re(b_re), .b_addr(b_addr),
        .mac_en(mac_en), .mac_clr(mac_clr), .out_sel(out_sel),
        .c_we(c_we), .c_addr(c_addr), .busy(busy), .done(done),
        .clock_count(clock_count)
    );

    always #5 clk = ~clk;

    int e = 0;  // index of the most recent rising edge
    always @(posedge clk) e++;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    endtask

    task automatic unexpected(input string name);
        n_total++;
        $display("FAIL %s: event with nothing expected (edge %0d)", name, e);
    endtask

    // ---------------- RAM + MAC lane stand-ins ----------------
    logic [63:0]        ram_a [8];
    logic [7:0]         ram_b [64];
    logic [63:0]        a_rd;
    logic [7:0]         b_rd;
    logic signed [18:0] lane [8];

    function automatic logic signed [18:0] prod(input logic signed [7:0] a, input logic signed [7:0] b);
        logic signed [18:0] ax, bx;
        ax = a;
        bx = b;
        return ax * bx;
    endfunction

    always @(posedge clk) begin
        if (a_re) a_rd <= ram_a[a_addr];
        if (b_re) b_rd <= ram_b[b_addr];
        if (mac_en)
            for (int j = 0; j < 8; j++)
                lane[j] <= (mac_clr ? 19'sd0 : lane[j]) + prod(a_rd[8*j +: 8], b_rd);
    end

    task automatic load_identity();
        for (int k = 0; k < 8; k++) begin
            ram_a[k] = '0;
            ram_a[k][8*k +: 8] = 8'd1;
        end
        for (int n = 0; n < 64; n++) ram_b[n] = 8'(n - 32);
    endtask

    task automatic load_neg128();
        for (int k = 0; k < 8; k++) ram_a[k] = {8{8'h80}};
        for (int n = 0; n < 64; n++) ram_b[n] = 8'h80;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { int e; int x; int y; } ev_t;
    ev_t rd_q[$];
    ev_t mac_q[$];
    ev_t wr_q[$];
    ev_t dn_q[$];

    // Expected events for a run whose start is sampled at edge s.
    // Cycle t of the run is observed after edge s+t-1.
    task automatic push_run(input int s, input bit neg128);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) begin
                rd_q.push_back('{s + 17*i + k, k, 8*i + k});
                mac_q.push_back('{s + 1 + 17*i + k, (k == 0) ? 1 : 0, 0});
            end
            for (int j = 0; j < 8; j++)
                wr_q.push_back('{s + 9 + 17*i + j, 8*i + j, neg128 ? 131072 : 8*i + j - 32});
        end
        dn_q.push_back('{s + 136, 136, 0});
    endtask

    always @(negedge clk) begin
        ev_t x;
        if (a_re) begin
            if (rd_q.size() == 0) unexpected("read");
            else begin
                x = rd_q.pop_front();
                chk("rd_cycle", e, x.e);
                chk("a_addr", int'(a_addr), x.x);
                chk("b_addr", int'(b_addr), x.y);
                chk("b_re", int'(b_re), 1);
            end
        end else
            chk("rd_idle_zero", int'({b_re, a_addr, b_addr}), 0);

        if (mac_en) begin
            if (mac_q.size() == 0) unexpected("mac_en");
            else begin
                x = mac_q.pop_front();
                chk("mac_cycle", e, x.e);
                chk("mac_clr", int'(mac_clr), x.x);
            end
        end else
            chk("mac_clr_idle", int'(mac_clr), 0);

        if (c_we) begin
            if (wr_q.size() == 0) unexpected("c_we");
            else begin
                x = wr_q.pop_front();
                chk("wr_cycle", e, x.e);
                chk("c_addr", int'(c_addr), x.x);
                chk("out_sel", int'(out_sel), x.x % 8);
                chk("c_data", int'(lane[out_sel]), x.y);
            end
        end else
            chk("wr_idle_zero", int'({c_addr, out_sel}), 0);

        if (done) begin
            if (dn_q.size() == 0) unexpected("done");
            else begin
                x = dn_q.pop_front();
                chk("done_cycle", e, x.e);
                chk("clock_count", int'(clock_count), x.x);
                chk("busy_at_done", int'(busy), 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic bit pending();
        return (rd_q.size() + mac_q.size() + wr_q.size() + dn_q.size()) != 0;
    endfunction

    task automatic wait_drain(input int bound);
        int n = 0;
        while (pending() && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (pending()) begin
            n_total++;
            $display("FAIL drain_timeout: %0d events still outstanding after %0d cycles", 
                     rd_q.size() + mac_q.size() + wr_q.size() + dn_q.size(), bound);
            rd_q.delete(); mac_q.delete(); wr_q.delete(); dn_q.delete();
        end
    endtask

    task automatic wait_edge(input int target);
        while (e < target) @(negedge clk);
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        s = e + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, int'({a_re, a_addr, b_re, b_addr, mac_en, mac_clr,
                                  out_sel, c_we, c_addr, busy, done}), 0);
        chk({tag, "_count"}, int'(clock_count), 0);
    endtask

    initial begin
        int s, s2;
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s, s2;
        load_identity();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_before_start", int'(busy), 0);

        // Run 1: identity A, output must reproduce B; covers column-3 trace.
        @(negedge clk);
        s = e + 1;
        push_run(s, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_cycle1", int'(busy), 1);
        wait_drain(300);
        wait_edge(s + 137);
        #1 chk("busy_cycle138", int'(busy), 0);

        // Run 2: A=B=-128, stray start at cycle 40 must be ignored.
        load_neg128();
        @(negedge clk);
        s = e + 1;
        push_run(s, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_edge(s + 39);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(300);
        wait_edge(s + 137);
        #1 chk("busy_after_stray", int'(busy), 0);

        // Held start: second run samples start one IDLE cycle after DONE.
        load_identity();
        @(negedge clk);
        s = e + 1;
        s2 = s + 138;
        push_run(s, 1'b0);
        push_run(s2, 1'b0);
        start = 1'b1;
        wait_edge(s2);
        start = 1'b0;
        wait_drain(600);
        wait_edge(s2 + 137);
        #1 chk("busy_after_held", int'(busy), 0);

        // Asynchronous reset in cycle 70, mid-cycle.
        pulse_start(s);
        push_run(s, 1'b0);
        wait_edge(s + 69);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        rd_q.delete(); mac_q.delete(); wr_q.delete(); dn_q.delete();
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("busy_after_reset", int'(busy), 0);

        // Fresh run after reset completes normally.
        @(negedge clk);
        s = e + 1;
        push_run(s, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(300);
        wait_edge(s + 137);
        #1 chk("busy_final", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
